// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: run/step sequencer between the board inputs and the riscv_i core.
// Produces a timed core reset after system reset, a clock enable that either
// free-runs at a programmable rate or single-steps from a debounced push button,
// and parks the core while it signals halt.
// Optional feature macro: CPU_CE_COUNT_EN adds a 32-bit count of enabled cycles.
module cpu_run_ctrl #(
  parameter int RST_HOLD   = 16,
  parameter int DIV_W      = 4,
  parameter int DEB_CYCLES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mode_run,
  input  logic             step_btn,
  input  logic [DIV_W-1:0] div_sel,
  input  logic             cpu_halt,
  output logic             cpu_reset,
  output logic             cpu_ce,
`ifdef CPU_CE_COUNT_EN
  output logic [31:0]      ce_count,
`endif
  output logic [1:0]       state
);

  localparam int HOLD_W = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
  localparam int DEB_W  = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD - 1);
  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_RESET = 2'b00,
    ST_RUN   = 2'b01,
    ST_STEP  = 2'b10,
    ST_HALT  = 2'b11
  } run_state_t;

  run_state_t        state_q, state_nx;
  logic [HOLD_W-1:0] hold_q, hold_nx;
  logic [DIV_W-1:0]  dc_q, dc_nx;
  logic [DIV_W-1:0]  div_q, div_nx;
  logic              ce_nx;
  logic              mode_s1, mode_s2;
  logic              step_s1, step_s2;
  logic              deb, deb_q;
  logic [DEB_W-1:0]  deb_cnt;
  logic              step_rise;

  // Bring the asynchronous switch and button into the clk domain.
  always_ff @(posedge clk) begin
    if (!reset) begin
      mode_s1 <= 1'b0;
      mode_s2 <= 1'b0;
      step_s1 <= 1'b0;
      step_s2 <= 1'b0;
    end else begin
      mode_s1 <= mode_run;
      mode_s2 <= mode_s1;
      step_s1 <= step_btn;
      step_s2 <= step_s1;
    end
  end

  // Accept a new button level only after it has held for DEB_CYCLES samples.
  always_ff @(posedge clk) begin
    if (!reset) begin
      deb     <= 1'b0;
      deb_q   <= 1'b0;
      deb_cnt <= '0;
    end else begin
      deb_q <= deb;
      if (step_s2 == deb) begin
        deb_cnt <= '0;
      end else if (deb_cnt == DEB_LAST) begin
        deb     <= step_s2;
        deb_cnt <= '0;
      end else begin
        deb_cnt <= deb_cnt + 1'b1;
      end
    end
  end

  assign step_rise = deb & ~deb_q;

  // State register plus the registered core reset and clock enable.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= ST_RESET;
      hold_q    <= '0;
      dc_q      <= '0;
      div_q     <= '0;
      cpu_reset <= 1'b1;
      cpu_ce    <= 1'b0;
    end else begin
      state_q   <= state_nx;
      hold_q    <= hold_nx;
      dc_q      <= dc_nx;
      div_q     <= div_nx;
      cpu_reset <= (state_nx == ST_RESET);
      cpu_ce    <= ce_nx;
    end
  end

  // Next state, counters and enable; the reset-exit edge already counts as the first run cycle.
  always_comb begin
    state_nx = state_q;
    hold_nx  = hold_q;
    dc_nx    = dc_q;
    div_nx   = div_q;
    ce_nx    = 1'b0;
    case (state_q)
      ST_RESET: begin
        if (hold_q == HOLD_LAST) begin
          hold_nx = '0;
          if (mode_s2) begin
            state_nx = ST_RUN;
            div_nx   = div_sel;
            if (div_sel == '0) begin
              ce_nx = 1'b1;
              dc_nx = '0;
            end else begin
              dc_nx = DIV_W'(1);
            end
          end else begin
            state_nx = ST_STEP;
            dc_nx    = '0;
          end
        end else begin
          hold_nx = hold_q + 1'b1;
        end
      end
      ST_RUN: begin
        if (cpu_halt) begin
          state_nx = ST_HALT;
        end else if (!mode_s2) begin
          state_nx = ST_STEP;
          dc_nx    = '0;
        end else if (dc_q == div_q) begin
          ce_nx  = 1'b1;
          dc_nx  = '0;
          div_nx = div_sel;
        end else begin
          dc_nx = dc_q + 1'b1;
        end
      end
      ST_STEP: begin
        if (cpu_halt) begin
          state_nx = ST_HALT;
        end else if (mode_s2) begin
          state_nx = ST_RUN;
          dc_nx    = '0;
          div_nx   = div_sel;
        end else begin
          ce_nx = step_rise;
        end
      end
      ST_HALT: begin
        if (step_rise) begin
          if (mode_s2) begin
            state_nx = ST_RUN;
            dc_nx    = '0;
            div_nx   = div_sel;
          end else begin
            state_nx = ST_STEP;
          end
        end
      end
      default: begin
        state_nx = ST_RESET;
      end
    endcase
  end

`ifdef CPU_CE_COUNT_EN
  // Count every cycle the core was enabled; wraps naturally at 2^32.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ce_count <= '0;
    end else if (cpu_ce) begin
      ce_count <= ce_count + 32'd1;
    end
  end
`endif

  assign state = state_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Self-checking bench for cpu_run_ctrl: directed scenarios with literal
// expectations followed by random stimulus, all checked against a
// schedule-based model of the sequencer.
module tb_cpu_run_ctrl;

  localparam int RST_HOLD   = 16;
  localparam int DIV_W      = 4;
  localparam int DEB_CYCLES = 4;

  logic             clk      = 1'b0;
  logic             reset    = 1'b0;
  logic             mode_run = 1'b0;
  logic             step_btn = 1'b0;
  logic             cpu_halt = 1'b0;
  logic [DIV_W-1:0] div_sel  = '0;
  logic             cpu_reset;
  logic             cpu_ce;
  logic [1:0]       state;
`ifdef CPU_CE_COUNT_EN
  logic [31:0]      ce_count;
`endif

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  cpu_run_ctrl #(
    .RST_HOLD(RST_HOLD),
    .DIV_W(DIV_W),
    .DEB_CYCLES(DEB_CYCLES)
  ) dut (
    .clk(clk),
    .reset(reset),
    .mode_run(mode_run),
    .step_btn(step_btn),
    .div_sel(div_sel),
    .cpu_halt(cpu_halt),
    .cpu_reset(cpu_reset),
    .cpu_ce(cpu_ce),
`ifdef CPU_CE_COUNT_EN
    .ce_count(ce_count),
`endif
    .state(state)
  );

  always #5 clk = ~clk;

  // Model: mode 0 RESET, 1 RUN, 2 STEP, 3 HALT. Free-run enables are kept as an
  // absolute edge number at which the next pulse is due.
  longint      edge_n = 0;
  longint      m_fire = 0;
  int          m_state = 0;
  int          m_hold = 0;
  int          m_streak = 0;
  bit          m_rst = 1'b1;
  bit          m_ce = 1'b0;
  bit          m_ms1 = 1'b0, m_ms2 = 1'b0;
  bit          m_bs1 = 1'b0, m_bs2 = 1'b0;
  bit          m_deb = 1'b0, m_debq = 1'b0;
  int unsigned m_cnt = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance the model by one clock edge using the inputs seen at that edge.
  always @(posedge clk) begin : model
    bit rise;
    bit old_ce;
    edge_n++;
    rise   = m_deb && !m_debq;
    old_ce = m_ce;
    if (!reset) begin
      m_state = 0; m_hold = 0; m_rst = 1'b1; m_ce = 1'b0; m_cnt = 0; m_fire = 0;
      m_ms1 = 0; m_ms2 = 0; m_bs1 = 0; m_bs2 = 0; m_deb = 0; m_debq = 0; m_streak = 0;
    end else begin
      if (old_ce) m_cnt++;
      m_ce = 1'b0;
      case (m_state)
        0: begin
          m_hold++;
          if (m_hold == RST_HOLD) begin
            m_rst = 1'b0;
            if (m_ms2) begin
              m_state = 1;
              m_fire  = edge_n + div_sel;
              if (m_fire == edge_n) begin
                m_ce   = 1'b1;
                m_fire = edge_n + div_sel + 1;
              end
            end else begin
              m_state = 2;
            end
          end
        end
        1: begin
          if (cpu_halt) m_state = 3;
          else if (!m_ms2) m_state = 2;
          else if (edge_n == m_fire) begin
            m_ce   = 1'b1;
            m_fire = edge_n + div_sel + 1;
          end
        end
        2: begin
          if (cpu_halt) m_state = 3;
          else if (m_ms2) begin
            m_state = 1;
            m_fire  = edge_n + 1 + div_sel;
          end else m_ce = rise;
        end
        default: begin
          if (rise) begin
            if (m_ms2) begin
              m_state = 1;
              m_fire  = edge_n + 1 + div_sel;
            end else m_state = 2;
          end
        end
      endcase
      m_debq = m_deb;
      if (m_bs2 == m_deb) m_streak = 0;
      else begin
        m_streak++;
        if (m_streak == DEB_CYCLES) begin
          m_deb    = m_bs2;
          m_streak = 0;
        end
      end
      m_bs2 = m_bs1; m_bs1 = step_btn;
      m_ms2 = m_ms1; m_ms1 = mode_run;
    end
  end

  // Compare the DUT against the model in the middle of every cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      checkOutput("cpu_reset", {31'd0, cpu_reset}, {31'd0, m_rst});
      checkOutput("cpu_ce", {31'd0, cpu_ce}, {31'd0, m_ce});
      checkOutput("state", {30'd0, state}, m_state);
`ifdef CPU_CE_COUNT_EN
      checkOutput("ce_count", ce_count, m_cnt);
`endif
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic applyStimulus(input bit r, input bit m, input bit s, input logic [DIV_W-1:0] d,
                               input bit h, input int cycles);
    reset = r; mode_run = m; step_btn = s; div_sel = d; cpu_halt = h;
    tick(cycles);
  endtask

  // Count cycles with cpu_reset high, then check the first released cycle.
  task automatic holdCount(output int n, input bit exp_ce);
    n = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (cpu_reset) n++;
      else break;
    end
    checkOutput("hold_exit_ce", {31'd0, cpu_ce}, {31'd0, exp_ce});
    checkOutput("hold_exit_state", {30'd0, state}, 32'd1);
    @(posedge clk);
    #2;
  endtask

  // Cycles from the current one up to and including the next enable pulse.
  task automatic waitCe(output int gap);
    gap = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      gap++;
      if (cpu_ce) break;
    end
    @(posedge clk);
    #2;
  endtask

  initial begin
    int n;
    int gap;
    bit found;

    $display("[TB] reset and hold");
    reset = 1'b0; mode_run = 1'b1; div_sel = '0;
    tick(1);
    chk_en = 1'b1;
    tick(2);
    reset = 1'b1;
    holdCount(n, 1'b1);
    checkOutput("t1_hold_len", n, 32'd16);

    $display("[TB] run rate change");
    div_sel = 4'd3;
    waitCe(gap);
    waitCe(gap);
    waitCe(gap);
    checkOutput("t2_period3", gap, 32'd4);
    div_sel = 4'd1;
    waitCe(gap);
    checkOutput("t2_period_finish", gap, 32'd4);
    waitCe(gap);
    checkOutput("t2_period1", gap, 32'd2);

    $display("[TB] single step with bounce");
    applyStimulus(1'b1, 1'b0, 1'b0, 4'd1, 1'b0, 4);
    step_btn = 1'b1; tick(1);
    step_btn = 1'b0; tick(1);
    step_btn = 1'b1;
    waitCe(gap);
    checkOutput("t3_step_delay", gap, 32'd8);
    n = 0;
    repeat (15) begin
      @(negedge clk);
      if (cpu_ce) n++;
    end
    checkOutput("t3_extra_pulses", n, 32'd0);
    checkOutput("t3_state", {30'd0, state}, 32'd2);
    tick(1);
    applyStimulus(1'b1, 1'b0, 1'b0, 4'd1, 1'b0, 10);

    $display("[TB] halt and resume");
    applyStimulus(1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 6);
    cpu_halt = 1'b1; tick(1);
    cpu_halt = 1'b0;
    @(negedge clk);
    checkOutput("t4_halt_state", {30'd0, state}, 32'd3);
    checkOutput("t4_halt_ce", {31'd0, cpu_ce}, 32'd0);
    tick(3);
    step_btn = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (state == 2'b01) begin
        found = 1'b1;
        break;
      end
    end
    checkOutput("t4_resume", {31'd0, found}, 32'd1);
    checkOutput("t4_exit_ce", {31'd0, cpu_ce}, 32'd0);
    @(negedge clk);
    checkOutput("t4_ce_resumes", {31'd0, cpu_ce}, 32'd1);
    tick(1);
    applyStimulus(1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 10);

    $display("[TB] reset mid-run");
    reset = 1'b0; tick(1);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("t5_ce", {31'd0, cpu_ce}, 32'd0);
    checkOutput("t5_reset", {31'd0, cpu_reset}, 32'd1);
    checkOutput("t5_state", {30'd0, state}, 32'd0);
    holdCount(n, 1'b1);
    checkOutput("t5_hold_rest", n, 32'd15);

    $display("[TB] enable count");
    div_sel = 4'd1;
    reset = 1'b0; tick(1);
    reset = 1'b1;
    holdCount(n, 1'b0);
    checkOutput("t6_hold_len", n, 32'd16);
    tick(99);
    @(negedge clk);
`ifdef CPU_CE_COUNT_EN
    checkOutput("t6_count", ce_count, 32'd50);
`endif
    tick(1);
    reset = 1'b0; tick(1);
    reset = 1'b1;
    @(negedge clk);
`ifdef CPU_CE_COUNT_EN
    checkOutput("t6_count_clear", ce_count, 32'd0);
`endif
    tick(1);

    $display("[TB] random phase");
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 49) == 0) mode_run = ~mode_run;
      if ($urandom_range(0, 9) == 0) step_btn = ~step_btn;
      if ($urandom_range(0, 19) == 0) div_sel = DIV_W'($urandom_range(0, (1 << DIV_W) - 1));
      cpu_halt = ($urandom_range(0, 39) == 0);
      reset = ($urandom_range(0, 499) == 0) ? 1'b0 : 1'b1;
      tick(1);
    end
    reset = 1'b1;
    cpu_halt = 1'b0;
    tick(2);
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cpu_run_ctrl.md
Name: cpu_run_ctrl

Overview:
Run/step sequencer that sits between board inputs and the riscv_i core. It replaces the free-running divider and the fixed reset pulse in the top level.
- Generates a timed, active-high core reset after system reset.
- Generates a clock-enable (cpu_ce) that runs the core at a programmable rate, or single-steps it from a debounced push button.
- Parks the core when it signals a halt.

Parameters:
RST_HOLD, 16, cycles cpu_reset stays high after reset deasserts (>=1)
DIV_W, 4, width of div_sel
DEB_CYCLES, 4, consecutive stable synchronized samples needed to accept a step_btn change (>=1; board build uses 500000)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-low reset
mode_run  in  1  async switch; 1 = free run, 0 = single step
step_btn  in  1  async raw push button, active-high
div_sel  in  DIV_W  free-run rate; cpu_ce every div_sel+1 cycles
cpu_halt  in  1  synchronous halt request from core (level)
cpu_reset  out  1  active-high reset to core
cpu_ce  out  1  clock-enable to core
state  out  2  00 RESET, 01 RUN, 10 STEP, 11 HALT

Behaviour:
- Reset (reset==0 at a clk edge): state=RESET, cpu_reset=1, cpu_ce=0, all counters 0, sync/debounce flops 0.
- Synchronizers: mode_run and step_btn each pass through a 2-flop synchronizer (s2 = synchronized value).
- Debounce, per edge:
  - If s2==deb: cnt<=0.
  - Else if cnt==DEB_CYCLES-1: deb<=s2, cnt<=0.
  - Else cnt<=cnt+1.
  - step_rise = deb & ~deb_q, with deb_q registered.
  - A step_btn edge that is stable from edge 0 sets deb at edge DEB_CYCLES+1; step_rise is therefore high during the following cycle.
  - mode_run is synchronized only, not debounced.
- RESET state:
  - hold counter runs 0..RST_HOLD-1 with cpu_reset=1.
  - At terminal count: cpu_reset<=0, and state<=RUN if synced mode_run==1, else STEP.
  - cpu_ce=0 throughout.
- RUN state:
  - div counter dc counts 0..div_sel.
  - cpu_ce is a registered output, high for exactly the cycle after the edge where dc==div_sel; dc wraps to 0 on that edge.
  - div_sel==0 gives cpu_ce=1 every cycle.
  - div_sel is sampled only at wrap; a change takes effect next period.
  - cpu_halt==1 sampled → state<=HALT; cpu_ce<=0 on that edge, even if a wrap coincides (halt wins).
  - synced mode_run==0 → state<=STEP, cpu_ce<=0, dc<=0.
- STEP state:
  - step_rise → cpu_ce<=1 for exactly one cycle.
  - Button held: no further pulses. Each release/press (after debounce) gives one pulse.
  - synced mode_run==1 → RUN, dc<=0.
  - cpu_halt==1 → HALT. If step_rise and cpu_halt occur in the same cycle, halt wins and no pulse is issued.
- HALT state:
  - cpu_ce=0.
  - step_rise → RUN if synced mode_run==1 (dc<=0), else STEP, in both cases with no ce pulse on exit.
  - cpu_halt is ignored in HALT.
- cpu_ce is never high while cpu_reset is high.
- reset low mid-operation returns everything to the reset values at the next edge and restarts the RST_HOLD count.
- Counter widths: clog2(RST_HOLD), DIV_W, clog2(DEB_CYCLES) (min 1 bit). No overflow is possible.

Optional Feature:
Macro CPU_CE_COUNT_EN.
- Defined:
  - Adds output ce_count, 32 bits.
  - Increments on every cycle cpu_ce==1 and wraps modulo 2^32.
  - Cleared by reset.
  - Holds its value through HALT/STEP.
- Undefined: the port and counter do not exist; behaviour is otherwise identical.

Test Plan:
1. Hold reset=0 for 3 cycles, then release with mode_run=1, div_sel=0: cpu_reset=1 for exactly 16 cycles after release, state=RESET; cpu_ce=1 every cycle from the cycle cpu_reset falls; state=01.
2. RUN with div_sel=3: cpu_ce period 4 cycles, duty one cycle; change div_sel to 1 mid-period → current period completes at 4, then period 2.
3. mode_run=0; step_btn bounces 1-0-1 within 3 cycles, then stays 1 for 20 cycles → exactly one cpu_ce pulse, at DEB_CYCLES+2 (=6) edges after the final stable rise sampled; no pulse from the bounce.
4. RUN, div_sel=0, assert cpu_halt for 1 cycle → cpu_ce low from that edge, state=11; step press → state=01 with no extra pulse, cpu_ce resumes.
5. Assert reset=0 while in RUN with cpu_ce high → next edge cpu_ce=0, cpu_reset=1, state=00; full 16-cycle hold repeats.
6. CPU_CE_COUNT_EN defined, div_sel=1, run 100 cycles post-reset-hold → ce_count=50; reset clears it to 0.
